mbox_cyc_arb: RTL

Cycle arbiter and sequencer for the MBOX cache/memory cycle. It chooses among four requesters (MB writeback, CCA sweep, channel, EBOX) and issues one-cycle grants. While each cycle runs it holds a level cycle indicator until the cache control logic reports completion. It also owns the EBOX page-fail hold and a starvation guard that keeps EBOX references moving under heavy channel or sweep traffic.

---
 rtl/mbox_cyc_arb_if.sv | 43 ++++
 rtl/mbox_cyc_arb.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mbox_cyc_arb_if.sv
// rtl/mbox_cyc_arb_if.sv - request/grant/cycle bundle between MBOX requesters and the cycle arbiter
//
// Signals (master = requesters and cache control, slave = arbiter):
//   mb_req, cca_req, chan_req, ebox_req      level requests, held until the matching grant
//   cyc_done                                 one-clock end-of-cycle pulse from cache control
//   page_fail, pf_clear                      EBOX page-fail indication and hold release pulse
//   *_req_grant                              one-clock grant pulses
//   mb_cyc, cca_cyc, chan_cyc, ebox_cyc      level cycle indicators, at most one high
//   ready_to_go                              arbiter idle and able to arbitrate
//   page_fail_hold                           EBOX blocked pending page-fail service
//   timeout_err                              one-clock watchdog expiry pulse
interface mbox_cyc_arb_if;
    logic mb_req;
    logic cca_req;
    logic chan_req;
    logic ebox_req;
    logic cyc_done;
    logic page_fail;
    logic pf_clear;
    logic mb_req_grant;
    logic cca_req_grant;
    logic chan_req_grant;
    logic ebox_req_grant;
    logic mb_cyc;
    logic cca_cyc;
    logic chan_cyc;
    logic ebox_cyc;
    logic ready_to_go;
    logic page_fail_hold;
    logic timeout_err;

    modport master (
        output mb_req, cca_req, chan_req, ebox_req, cyc_done, page_fail, pf_clear,
        input  mb_req_grant, cca_req_grant, chan_req_grant, ebox_req_grant,
        input  mb_cyc, cca_cyc, chan_cyc, ebox_cyc, ready_to_go, page_fail_hold, timeout_err
    );

    modport slave (
        input  mb_req, cca_req, chan_req, ebox_req, cyc_done, page_fail, pf_clear,
        output mb_req_grant, cca_req_grant, chan_req_grant, ebox_req_grant,
        output mb_cyc, cca_cyc, chan_cyc, ebox_cyc, ready_to_go, page_fail_hold, timeout_err
    );
endinterface

// File: rtl/mbox_cyc_arb.sv
// rtl/mbox_cyc_arb.sv - MBOX cache/memory cycle arbiter with EBOX page-fail hold and starvation guard
//
// Ports:
//   clk    MBOX clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mbox_cyc_arb_if.slave: requests, cyc_done, page_fail, pf_clear in;
//          grants, cycle levels, ready_to_go, page_fail_hold, timeout_err out
// Parameters:
//   STARVE_LIMIT    lost arbitrations with EBOX pending before EBOX is promoted (1..255)
//   TIMEOUT_CYCLES  BUSY clocks before the watchdog aborts a cycle (2..1023)
// Build option:
//   MBOX_ARB_TIMEOUT_EN  compiles in the cycle watchdog; otherwise timeout_err is tied 0
module mbox_cyc_arb #(
    parameter int STARVE_LIMIT   = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    mbox_cyc_arb_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Bit positions in the request/grant/cycle vectors.
    localparam int MB   = 0;
    localparam int CCA  = 1;
    localparam int CHAN = 2;
    localparam int EBOX = 3;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] cyc_q, cyc_d;
    logic       ready_q;
    logic       hold_q, hold_d;
    logic [7:0] starve_q, starve_d;
    logic [3:0] req, elig, win;
    logic       promoted;

`ifdef MBOX_ARB_TIMEOUT_EN
    localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0] wdog_q, wdog_d;
    logic       terr_q, terr_d;
`endif

    assign req      = {bus.ebox_req, bus.chan_req, bus.cca_req, bus.mb_req};
    // A page-faulted EBOX may not re-enter until the fault has been serviced.
    assign elig     = {req[EBOX] & ~hold_q, req[CHAN:MB]};
    assign promoted = (starve_q == STARVE_MAX);

    // Winner select; a starved EBOX jumps ahead of CCA and CHAN but never MB.
    always_comb begin
        win = 4'b0000;
        if (elig[MB])                     win[MB]   = 1'b1;
        else if (promoted && elig[EBOX])  win[EBOX] = 1'b1;
        else if (elig[CCA])               win[CCA]  = 1'b1;
        else if (elig[CHAN])              win[CHAN] = 1'b1;
        else if (elig[EBOX])              win[EBOX] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        grant_d = 4'b0000;
        cyc_d   = cyc_q;
        // A page-fail set later in this block overrides a same-clock clear.
        hold_d  = hold_q & ~bus.pf_clear;
`ifdef MBOX_ARB_TIMEOUT_EN
        wdog_d  = wdog_q;
        terr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    grant_d = win;
                    cyc_d   = win;
                    state_d = BUSY;
`ifdef MBOX_ARB_TIMEOUT_EN
                    wdog_d  = 10'd0;
`endif
                end
            end
            BUSY: begin
                // Page fail beats completion, completion beats the watchdog.
                if (cyc_q[EBOX] && bus.page_fail) begin
                    cyc_d   = 4'b0000;
                    hold_d  = 1'b1;
                    state_d = IDLE;
                end else if (bus.cyc_done) begin
                    cyc_d   = 4'b0000;
                    state_d = IDLE;
                end
`ifdef MBOX_ARB_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    cyc_d   = 4'b0000;
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_d  = wdog_q + 10'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Counts arbitrations EBOX loses while it is actually eligible.
    always_comb begin
        starve_d = starve_q;
        if (!bus.ebox_req) begin
            starve_d = 8'd0;
        end else if (state_q == IDLE && win[EBOX]) begin
            starve_d = 8'd0;
        end else if (state_q == IDLE && (|win[CHAN:MB]) && !hold_q && !promoted) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= 4'b0000;
            cyc_q    <= 4'b0000;
            ready_q  <= 1'b1;
            hold_q   <= 1'b0;
            starve_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cyc_q    <= cyc_d;
            ready_q  <= (state_d == IDLE);
            hold_q   <= hold_d;
            starve_q <= starve_d;
        end
    end

`ifdef MBOX_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= 10'd0;
            terr_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            terr_q <= terr_d;
        end
    end

    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.mb_req_grant   = grant_q[MB];
    assign bus.cca_req_grant  = grant_q[CCA];
    assign bus.chan_req_grant = grant_q[CHAN];
    assign bus.ebox_req_grant = grant_q[EBOX];
    assign bus.mb_cyc         = cyc_q[MB];
    assign bus.cca_cyc        = cyc_q[CCA];
    assign bus.chan_cyc       = cyc_q[CHAN];
    assign bus.ebox_cyc       = cyc_q[EBOX];
    assign bus.ready_to_go    = ready_q;
    assign bus.page_fail_hold = hold_q;
endmodule
